// File: rtl/iic_s_phy_timing.sv
// I2C slave bit/byte engine: synchronised pin sampling, address match, ACK/NACK, read data and SCL stretching.
// Latency: 3 cycles pin-to-detect. Backpressure: SCL is stretched while tx_valid is low; a write byte is NACKed when rx_ready is low.
module iic_s_phy_timing #(
    parameter int         U_DLY    = 1,
    parameter logic [6:0] SLV_ADDR = 7'h50
) (
    input  logic       clk_sys,
    input  logic       rst_n,
    input  logic       iic_sck_i,
    output logic       iic_sck_o,
    output logic       iic_sck_t,
    input  logic       iic_sda_i,
    output logic       iic_sda_o,
    output logic       iic_sda_t,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       start_det,
    output logic       stop_det,
    output logic       rd_nack,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_WR_DATA, S_WR_ACK, S_RD_DATA, S_RD_ACK, S_IGNORE
    } state_t;

    state_t     state;
    logic [2:0] scl_sync;
    logic [2:0] sda_sync;
    logic [2:0] bit_cnt;
    logic [7:0] rx_sh;
    logic [7:0] tx_sh;
    logic       rw;
    logic       sck_rel;

    logic       scl_s, scl_h, sda_s, sda_h;
    logic       scl_rise, scl_fall, start_cond, stop_cond;
    logic [7:0] rx_byte;
    logic       rd_load, tx_take;
    logic       unused_dly;

    assign unused_dly = (U_DLY != 0);

    assign scl_s      = scl_sync[1];
    assign scl_h      = scl_sync[2];
    assign sda_s      = sda_sync[1];
    assign sda_h      = sda_sync[2];
    assign scl_rise   = scl_s & ~scl_h;
    assign scl_fall   = ~scl_s & scl_h;
    assign start_cond = scl_s & sda_h & ~sda_s;
    assign stop_cond  = scl_s & ~sda_h & sda_s;
    assign rx_byte    = {rx_sh[6:0], sda_s};

    // Read byte fetch happens on the SCL fall that closes an address ACK (read) or a master ACK.
    assign rd_load = scl_fall & (((state == S_ADDR_ACK) & iic_sda_t & rw) | (state == S_RD_ACK));
    assign tx_take = tx_valid & (rd_load | ((state == S_RD_DATA) & iic_sck_t & ~sck_rel));

    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            scl_sync  <= 3'b111;
            sda_sync  <= 3'b111;
            state     <= S_IDLE;
            bit_cnt   <= 3'd0;
            rx_sh     <= 8'h00;
            tx_sh     <= 8'h00;
            rw        <= 1'b0;
            sck_rel   <= 1'b0;
            iic_sda_o <= 1'b1;
            iic_sda_t <= 1'b0;
            iic_sck_o <= 1'b1;
            iic_sck_t <= 1'b0;
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            tx_ready  <= 1'b0;
            start_det <= 1'b0;
            stop_det  <= 1'b0;
            rd_nack   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            scl_sync  <= {scl_sync[1:0], iic_sck_i};
            sda_sync  <= {sda_sync[1:0], iic_sda_i};
            rx_valid  <= 1'b0;
            tx_ready  <= 1'b0;
            start_det <= 1'b0;
            stop_det  <= 1'b0;
            rd_nack   <= 1'b0;
            if (start_cond) begin
                state     <= S_ADDR;
                bit_cnt   <= 3'd0;
                iic_sda_o <= 1'b1;
                iic_sda_t <= 1'b0;
                start_det <= 1'b1;
                busy      <= 1'b1;
            end else if (stop_cond) begin
                state     <= S_IDLE;
                bit_cnt   <= 3'd0;
                iic_sda_o <= 1'b1;
                iic_sda_t <= 1'b0;
                iic_sck_o <= 1'b1;
                iic_sck_t <= 1'b0;
                sck_rel   <= 1'b0;
                stop_det  <= 1'b1;
                busy      <= 1'b0;
            end else begin
                case (state)
                    S_ADDR: if (scl_rise) begin
                        rx_sh   <= rx_byte;
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            rw    <= rx_byte[0];
                            state <= (rx_byte[7:1] == SLV_ADDR) ? S_ADDR_ACK : S_IGNORE;
                        end
                    end
                    // First fall after the byte pulls SDA low, the next fall lets it go.
                    S_ADDR_ACK, S_WR_ACK: if (scl_fall) begin
                        if (!iic_sda_t) begin
                            iic_sda_t <= 1'b1;
                            iic_sda_o <= 1'b0;
                        end else begin
                            iic_sda_t <= 1'b0;
                            iic_sda_o <= 1'b1;
                            if (state == S_WR_ACK || !rw)
                                state <= S_WR_DATA;
                        end
                    end
                    S_WR_DATA: if (scl_rise) begin
                        rx_sh   <= rx_byte;
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            rx_data  <= rx_byte;
                            rx_valid <= 1'b1;
                            state    <= rx_ready ? S_WR_ACK : S_IGNORE;
                        end
                    end
                    S_RD_DATA: begin
                        if (iic_sck_t) begin
                            if (sck_rel) begin
                                iic_sck_t <= 1'b0;
                                iic_sck_o <= 1'b1;
                                sck_rel   <= 1'b0;
                            end
                        end else if (scl_rise) begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end else if (scl_fall) begin
                            if (bit_cnt == 3'd0) begin
                                iic_sda_t <= 1'b0;
                                iic_sda_o <= 1'b1;
                                state     <= S_RD_ACK;
                            end else begin
                                iic_sda_o <= tx_sh[3'd7 - bit_cnt];
                                iic_sda_t <= ~tx_sh[3'd7 - bit_cnt];
                            end
                        end
                    end
                    S_RD_ACK: if (scl_rise && sda_s) begin
                        rd_nack <= 1'b1;
                        state   <= S_IGNORE;
                    end
                    default: ;
                endcase
                if (rd_load) begin
                    state   <= S_RD_DATA;
                    bit_cnt <= 3'd0;
                    if (!tx_valid) begin
                        iic_sck_o <= 1'b0;
                        iic_sck_t <= 1'b1;
                    end
                end
                if (tx_take) begin
                    tx_sh     <= tx_data;
                    tx_ready  <= 1'b1;
                    iic_sda_o <= tx_data[7];
                    iic_sda_t <= ~tx_data[7];
                    if (iic_sck_t)
                        sck_rel <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_iic_s_phy_timing.sv
// Directed bench for iic_s_phy_timing: an open-drain I2C master model with scoreboard queues for written bytes and read bits.
module tb_iic_s_phy_timing;

    localparam int Q = 8;

    logic       clk_sys  = 1'b0;
    logic       rst_n    = 1'b0;
    logic       m_scl    = 1'b1;
    logic       m_sda    = 1'b1;
    logic       rx_ready = 1'b1;
    logic [7:0] tx_data  = 8'h00;
    logic       tx_valid = 1'b0;

    logic       iic_sck_o, iic_sck_t, iic_sda_o, iic_sda_t;
    logic [7:0] rx_data;
    logic       rx_valid, tx_ready, start_det, stop_det, rd_nack, busy;
    logic       scl_bus, sda_bus;

    assign scl_bus = m_scl & (iic_sck_t ? iic_sck_o : 1'b1);
    assign sda_bus = m_sda & (iic_sda_t ? iic_sda_o : 1'b1);

    iic_s_phy_timing #(.U_DLY(1), .SLV_ADDR(7'h50)) dut (
        .clk_sys   (clk_sys),
        .rst_n     (rst_n),
        .iic_sck_i (scl_bus),
        .iic_sck_o (iic_sck_o),
        .iic_sck_t (iic_sck_t),
        .iic_sda_i (sda_bus),
        .iic_sda_o (iic_sda_o),
        .iic_sda_t (iic_sda_t),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .start_det (start_det),
        .stop_det  (stop_det),
        .rd_nack   (rd_nack),
        .busy      (busy)
    );

    always #5 clk_sys = ~clk_sys;

    int n_assert = 0;
    int n_fail   = 0;
    int c_rx = 0, c_txr = 0, c_start = 0, c_stop = 0, c_nack = 0;
    int c_sda_drv = 0, c_sda_hi = 0, c_sck_hi = 0;
    logic sda_t_q = 1'b0;
    bit   mon_en  = 1'b0;

    logic [7:0] exp_rx[$];
    logic       exp_bits[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_rng(input string tag, input int val, input int lo, input int hi);
        n_assert++;
        assert (val >= lo && val <= hi) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d..%0d", tag, val, lo, hi);
        end
    endtask

    // Output monitor: pops the write scoreboard, counts strobes, checks pins are never driven high.
    always @(negedge clk_sys) begin
        if (mon_en) begin
            if (rx_valid === 1'b1) begin
                c_rx++;
                check("rx_valid_expected", 32'(exp_rx.size() != 0), 1);
                if (exp_rx.size() != 0)
                    check("rx_data_sb", 32'(rx_data), 32'(exp_rx.pop_front()));
            end
            if (tx_ready === 1'b1)  c_txr++;
            if (start_det === 1'b1) c_start++;
            if (stop_det === 1'b1)  c_stop++;
            if (rd_nack === 1'b1)   c_nack++;
            check("sda_never_high", 32'(iic_sda_t & iic_sda_o), 0);
            check("scl_never_high", 32'(iic_sck_t & iic_sck_o), 0);
            if (iic_sda_t === 1'b1 && sda_t_q !== 1'b1) c_sda_drv++;
            if (iic_sda_t === 1'b1) c_sda_hi++;
            if (iic_sck_t === 1'b1) c_sck_hi++;
            sda_t_q = iic_sda_t;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic scl_up();
        m_scl = 1'b1;
        for (int i = 0; i < 2000 && scl_bus !== 1'b1; i++) tick(1);
        if (scl_bus !== 1'b1) check("scl_release_timeout", 32'(scl_bus), 1);
    endtask

    task automatic i2c_start();
        m_sda = 1'b0; tick(Q);
        m_scl = 1'b0; tick(Q);
    endtask

    task automatic i2c_rstart();
        m_sda = 1'b1; tick(Q);
        scl_up();     tick(Q);
        m_sda = 1'b0; tick(Q);
        m_scl = 1'b0; tick(Q);
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; tick(Q);
        scl_up();     tick(Q);
        m_sda = 1'b1; tick(2 * Q);
    endtask

    task automatic wbit(input logic b);
        m_sda = b; tick(Q);
        scl_up();  tick(2 * Q);
        m_scl = 1'b0; tick(Q);
    endtask

    task automatic rbit(output logic b);
        m_sda = 1'b1; tick(Q);
        scl_up();     tick(Q);
        b = sda_bus;  tick(Q);
        m_scl = 1'b0; tick(Q);
    endtask

    task automatic wbyte(input logic [7:0] v, output logic ack);
        for (int i = 7; i >= 0; i--) wbit(v[i]);
        rbit(ack);
    endtask

    task automatic rbyte(input string tag, input logic m_ack, output logic [7:0] d);
        logic b;
        d = 8'h00;
        for (int i = 0; i < 8; i++) begin
            rbit(b);
            d = {d[6:0], b};
            check({tag, "_pending"}, 32'(exp_bits.size() != 0), 1);
            if (exp_bits.size() != 0) check(tag, 32'(b), 32'(exp_bits.pop_front()));
        end
        wbit(m_ack ? 1'b0 : 1'b1);
    endtask

    task automatic push_bits(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) exp_bits.push_back(v[i]);
    endtask

    task automatic wait_txr(input string tag);
        for (int i = 0; i < 2000 && tx_ready !== 1'b1; i++) tick(1);
        check(tag, 32'(tx_ready), 1);
        tick(1);
    endtask

    function automatic logic [31:0] rst_vec();
        return 32'({iic_sda_o, iic_sda_t, iic_sck_o, iic_sck_t, rx_data,
                    rx_valid, tx_ready, start_det, stop_det, rd_nack, busy});
    endfunction

    logic       ack;
    logic [7:0] d0, d1;
    int         s_rx, s_txr, s_st, s_sp, s_nack, s_drv, s_hi, s_sck;

    initial begin
        // Reset state
        rst_n = 1'b0;
        tick(3);
        check("reset_outputs", rst_vec(), 32'h0002_8000);
        rst_n = 1'b1;
        tick(2);
        sda_t_q = iic_sda_t;
        mon_en  = 1'b1;

        // Write 0x3C to address 0x50
        s_rx = c_rx; s_st = c_start; s_sp = c_stop; s_drv = c_sda_drv;
        rx_ready = 1'b1;
        i2c_start();
        check("wr_busy_after_start", 32'(busy), 1);
        check("wr_start_det", 32'(c_start - s_st), 1);
        wbyte(8'hA0, ack);
        check("wr_addr_ack", 32'(ack), 0);
        exp_rx.push_back(8'h3C);
        wbyte(8'h3C, ack);
        check("wr_data_ack", 32'(ack), 0);
        check("wr_busy_mid", 32'(busy), 1);
        i2c_stop();
        check("wr_busy_after_stop", 32'(busy), 0);
        check("wr_stop_det", 32'(c_stop - s_sp), 1);
        check("wr_rx_count", 32'(c_rx - s_rx), 1);
        check("wr_rx_data_hold", 32'(rx_data), 32'h3C);
        check("wr_ack_pulses", 32'(c_sda_drv - s_drv), 2);
        check("wr_sb_drained", 32'(exp_rx.size()), 0);

        // Address mismatch: 0x51 must be ignored entirely
        s_rx = c_rx; s_hi = c_sda_hi;
        i2c_start();
        wbyte(8'hA2, ack);
        check("mm_addr_nack", 32'(ack), 1);
        wbyte(8'h11, ack);
        check("mm_data_nack", 32'(ack), 1);
        i2c_stop();
        check("mm_sda_never_driven", 32'(c_sda_hi - s_hi), 0);
        check("mm_no_rx_valid", 32'(c_rx - s_rx), 0);
        check("mm_busy_after_stop", 32'(busy), 0);

        // Read with clock stretch: tx_valid arrives 50 cycles into the stretch
        s_txr = c_txr; s_nack = c_nack; s_sck = c_sck_hi;
        tx_valid = 1'b0;
        i2c_start();
        wbyte(8'hA1, ack);
        check("rd_addr_ack", 32'(ack), 0);
        fork
            rbyte("rd_bit", 1'b0, d0);
            begin
                for (int i = 0; i < 200 && iic_sck_t !== 1'b1; i++) tick(1);
                check("rd_stretch_started", 32'(iic_sck_t), 1);
                tick(50);
                tx_data = 8'hA5;
                push_bits(8'hA5);
                tx_valid = 1'b1;
                wait_txr("rd_tx_ready_seen");
                tx_valid = 1'b0;
            end
        join
        i2c_stop();
        check("rd_data", 32'(d0), 32'hA5);
        check("rd_tx_ready_count", 32'(c_txr - s_txr), 1);
        check("rd_nack_count", 32'(c_nack - s_nack), 1);
        check_rng("rd_stretch_cycles", c_sck_hi - s_sck, 50, 60);

        // Write NACK when rx_ready is low
        s_rx = c_rx;
        rx_ready = 1'b0;
        i2c_start();
        wbyte(8'hA0, ack);
        check("wn_addr_ack", 32'(ack), 0);
        exp_rx.push_back(8'h55);
        wbyte(8'h55, ack);
        check("wn_data_nack", 32'(ack), 1);
        wbyte(8'h99, ack);
        check("wn_next_ignored", 32'(ack), 1);
        i2c_stop();
        check("wn_rx_count", 32'(c_rx - s_rx), 1);
        check("wn_sb_drained", 32'(exp_rx.size()), 0);
        rx_ready = 1'b1;

        // Repeated START: write address, then read two bytes
        s_txr = c_txr; s_st = c_start; s_nack = c_nack;
        tx_data = 8'h5A;
        push_bits(8'h5A);
        tx_valid = 1'b1;
        i2c_start();
        wbyte(8'hA0, ack);
        check("rs_wr_addr_ack", 32'(ack), 0);
        i2c_rstart();
        fork
            begin
                wbyte(8'hA1, ack);
                check("rs_rd_addr_ack", 32'(ack), 0);
                rbyte("rs_b0", 1'b1, d0);
                rbyte("rs_b1", 1'b0, d1);
            end
            begin
                wait_txr("rs_tx_ready0");
                tx_data = 8'hC3;
                push_bits(8'hC3);
                wait_txr("rs_tx_ready1");
                tx_valid = 1'b0;
            end
        join
        i2c_stop();
        check("rs_byte0", 32'(d0), 32'h5A);
        check("rs_byte1", 32'(d1), 32'hC3);
        check("rs_start_count", 32'(c_start - s_st), 2);
        check("rs_tx_ready_count", 32'(c_txr - s_txr), 2);
        check("rs_nack_count", 32'(c_nack - s_nack), 1);

        // Reset while the address ACK is being driven
        s_txr = c_txr; s_rx = c_rx;
        i2c_start();
        for (int i = 7; i >= 0; i--) wbit(1'((8'hA1 >> i) & 8'h01));
        m_sda = 1'b1;
        check("rst_ack_drive_before", 32'(iic_sda_t), 1);
        rst_n = 1'b0;
        tick(1);
        check("rst_sda_released", 32'(iic_sda_t), 0);
        check("rst_mid_outputs", rst_vec(), 32'h0002_8000);
        tick(2);
        rst_n = 1'b1;
        rbit(ack);
        check("rst_ack_released", 32'(ack), 1);
        wbyte(8'hA0, ack);
        check("rst_bus_ignored", 32'(ack), 1);
        i2c_stop();
        check("rst_no_tx_ready", 32'(c_txr - s_txr), 0);
        check("rst_no_rx_valid", 32'(c_rx - s_rx), 0);
        i2c_start();
        wbyte(8'hA0, ack);
        check("rst_recover_ack", 32'(ack), 0);
        i2c_stop();

        tick(10);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog expired observed=timeout expected=completion");
        $fatal(1, "watchdog");
    end

endmodule
